// File: rtl/mcu_pkg.sv
// Shared MCU datapath definitions: clear-sequencer states and default widths.
package mcu_pkg;

   localparam int unsigned MCU_DATA_W = 8;
   localparam int unsigned MCU_ADDR_W = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_e;

endpackage : mcu_pkg

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: walks a counter over every register-file entry after a CLR pulse.
module regfile_clr_seq
   import mcu_pkg::*;
#(
   parameter int unsigned ADDR_W = MCU_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   output logic              busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);

   clr_state_e        state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              busy_q, busy_d;

   // State, counter and busy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state: CLR is only honoured from IDLE, so a pulse while clearing cannot restart it.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      unique case (state_q)
         IDLE: begin
            if (clr) begin
               state_d = CLEAR;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end
         end
         CLEAR: begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == '1) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // All outputs come straight from flops.
   assign busy     = busy_q;
   assign clr_we   = (state_q == CLEAR);
   assign clr_addr = cnt_q;

endmodule : regfile_clr_seq

// File: rtl/regfile_param.sv
// Parametrised two-read/one-write register file with registered, bypassed reads and hardware clear.
module regfile_param
   import mcu_pkg::*;
#(
   parameter int unsigned DATA_W  = MCU_DATA_W,
   parameter int unsigned ADDR_W  = MCU_ADDR_W,
   parameter bit          ZERO_R0 = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              EN,
   input  logic              WR,
   input  logic [ADDR_W-1:0] Write_Addr,
   input  logic [DATA_W-1:0] Write_Data,
   input  logic [ADDR_W-1:0] Read_Addr1,
   input  logic [ADDR_W-1:0] Read_Addr2,
   input  logic              CLR,
   output logic [DATA_W-1:0] Dout1,
   output logic [DATA_W-1:0] Dout2,
   output logic              Busy
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DATA_W-1:0] dout1_q, dout1_d;
   logic [DATA_W-1:0] dout2_q, dout2_d;

   logic              busy;
   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              wr_acc;
   logic              wr_en;

   regfile_clr_seq #(
      .ADDR_W (ADDR_W)
   ) u_clr_seq (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (CLR),
      .busy     (busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   // A write is accepted outside a clear; the hard-wired zero entry silently drops it.
   assign wr_acc = EN && WR && !busy;
   assign wr_en  = wr_acc && !(ZERO_R0 && (Write_Addr == ADDR_W'(0)));

   // Read value for one port: zero entry first, then same-edge bypass, then storage.
   function automatic logic [DATA_W-1:0] port_val(
      input logic [ADDR_W-1:0] addr,
      input logic [DATA_W-1:0] stored,
      input logic              byp_en,
      input logic [ADDR_W-1:0] byp_addr,
      input logic [DATA_W-1:0] byp_data
   );
      logic [DATA_W-1:0] val;
      val = stored;
      if (ZERO_R0 && (addr == ADDR_W'(0))) begin
         val = '0;
      end else if (byp_en && (addr == byp_addr)) begin
         val = byp_data;
      end
      return val;
   endfunction

   // Storage array registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   // Write mux: the clear sequencer owns the array while it runs.
   always_comb begin
      mem_d = mem_q;
      if (clr_we) begin
         mem_d[clr_addr] = '0;
      end else if (wr_en) begin
         mem_d[Write_Addr] = Write_Data;
      end
   end

   // Read output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout1_q <= '0;
         dout2_q <= '0;
      end else begin
         dout1_q <= dout1_d;
         dout2_q <= dout2_d;
      end
   end

   // Read data: forced to zero during a clear, held while disabled.
   always_comb begin
      dout1_d = dout1_q;
      dout2_d = dout2_q;
      if (busy) begin
         dout1_d = '0;
         dout2_d = '0;
      end else if (EN) begin
         dout1_d = port_val(Read_Addr1, mem_q[Read_Addr1], wr_acc, Write_Addr, Write_Data);
         dout2_d = port_val(Read_Addr2, mem_q[Read_Addr2], wr_acc, Write_Addr, Write_Data);
      end
   end

   assign Dout1 = dout1_q;
   assign Dout2 = dout2_q;
   assign Busy  = busy;

endmodule : regfile_param

// File: doc/regfile_param.md
# regfile_param

Parametrised multi-port register file for the 8-bit MCU datapath, succeeding the fixed 16×8 two-read/one-write register file.

- Width and depth are configurable; register 0 can optionally be hard-wired to zero.
- Read ports are registered with same-cycle write-to-read bypass.
- A hardware clear sequencer zeroes the whole array on request, with a Busy handshake.
- Sits between the instruction decoder (addresses, WR, CLR) and the ALU operand inputs (Dout1/Dout2).

## Interface
Parameters:
- DATA_W, 8, data width in bits
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries
- ZERO_R0, 0, when 1 entry 0 always reads 0 and ignores writes

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- EN  in  1  block enable; gates reads and writes
- WR  in  1  write strobe (valid with EN=1)
- Write_Addr  in  ADDR_W  write address
- Write_Data  in  DATA_W  write data
- Read_Addr1  in  ADDR_W  read port 1 address
- Read_Addr2  in  ADDR_W  read port 2 address
- CLR  in  1  clear-all request, single-cycle pulse
- Dout1  out  DATA_W  registered read data, port 1
- Dout2  out  DATA_W  registered read data, port 2
- Busy  out  1  high while the clear sequence runs

## Operation
- **Reset (rst_n=0, async):**
  - All entries 0; Dout1=Dout2=0; Busy=0; FSM=IDLE; clear counter 0.
- **Write:**
  - Occurs at the edge where EN=1, WR=1, Busy=0: mem[Write_Addr] <= Write_Data.
  - Ignored if ZERO_R0=1 and Write_Addr=0.
- **Read:**
  - At every edge where EN=1, Busy=0: DoutN <= mem[Read_AddrN]. Reads do not depend on WR; a simultaneous read and write is legal.
  - Bypass: if a write is accepted at the same edge and Read_AddrN == Write_Addr, DoutN <= Write_Data. The ZERO_R0 rule takes precedence over bypass, so address 0 yields 0.
  - EN=0: Dout1/Dout2 hold their values.
- **Clear FSM:**
  - States IDLE and CLEAR.
  - IDLE→CLEAR at an edge with CLR=1 (EN ignored); counter <= 0, Busy <= 1.
  - CLEAR: each edge writes 0 to mem[counter] and increments the counter. After entry DEPTH-1 is cleared, the FSM goes to IDLE and Busy <= 0.
  - During Busy: writes are dropped, Dout1/Dout2 are forced to 0, and CLR is ignored (no restart).
- **Simultaneous CLR and write in IDLE:** the write is performed at that edge, and the clear then overwrites it.
- **Reset mid-clear:** immediate return to IDLE with all entries 0; no partial state remains.

## Timing
- Read latency is 1 cycle: an address presented before edge N appears on Dout at edge N.
- A write at edge N is visible:
  - on the same edge through bypass, or
  - through a plain read at edge N+1 and later.
- Clear timing for CLR sampled at edge N:
  - Busy is high after edge N.
  - Entry k is cleared at edge N+1+k.
  - Busy falls at edge N+DEPTH.
  - The first write is accepted at edge N+DEPTH+1.
- Busy is high for exactly DEPTH cycles.
- No combinational path from any input to any output.

## Structure
- **Shared package `mcu_pkg`:**
  - state enum (IDLE, CLEAR)
  - default DATA_W/ADDR_W constants, shared with the decoder and ALU
- **Sub-module `regfile_clr_seq`:** FSM plus ADDR_W-bit counter. It outputs Busy, clr_we and clr_addr.
- **Top level:** storage array, write mux (clear has priority over user write), bypass compare and output registers.
- Storage is flop-based, with asynchronous reset on every entry.

## Test plan
- Default params. Reset, then read addresses 0 and 15 with EN=1 → Dout1=Dout2=0x00, Busy=0.
- Write 0xFF to addr 0 and 0xF7 to addr 1; then WR=0, Read_Addr1=1, Read_Addr2=0 → one cycle later Dout1=0xF7, Dout2=0xFF.
- Same-edge write of 0x5A to addr 3 with Read_Addr1=3 → Dout1=0x5A at that edge; Dout2 (addr 4) shows the old value.
- Fill all 16 entries with nonzero data, pulse CLR:
  - Busy high for exactly 16 cycles.
  - A write issued mid-clear is dropped.
  - Dout=0 while Busy.
  - Afterwards every entry reads 0x00.
  - A second CLR pulse during Busy does not extend it.
- ZERO_R0=1, DATA_W=16, ADDR_W=3:
  - Write 0xBEEF to addr 0 → reads 0x0000.
  - Write 0xBEEF to addr 7 → reads 0xBEEF.
  - Bypass to addr 0 also yields 0x0000.
- Assert rst_n low at clear cycle 5 → Busy=0 and all Dout=0 immediately. Writes are accepted on the first edge after deassertion.
